// File: rtl/expr_eval_if.sv
// rtl/expr_eval_if.sv - character stream in / evaluated value out bundle for expr_eval
// The ovf signal exists only when EXPR_EVAL_OVF_EN is defined.
interface expr_eval_if #(
    parameter int W = 8
);
    logic [7:0]   in;
    logic         in_vld;
    logic [W-1:0] value;
    logic         ok;
    logic         err;
`ifdef EXPR_EVAL_OVF_EN
    logic         ovf;

    modport master (output in, in_vld, input value, ok, err, ovf);
    modport slave  (input in, in_vld, output value, ok, err, ovf);
`else
    modport master (output in, in_vld, input value, ok, err);
    modport slave  (input in, in_vld, output value, ok, err);
`endif
endinterface

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - one-char-per-clock evaluator for digit/'+'/'*'/one-paren-level expressions
// Optional sticky overflow flag enabled by defining EXPR_EVAL_OVF_EN.
module expr_eval #(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        clr_n,
    expr_eval_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OPND = 2'd0,
        ST_OPR  = 2'd1,
        ST_ERR  = 2'd2
    } st_e;

    st_e          st_q, st_d;
    logic         depth_q, depth_d;
    logic [W-1:0] sum_q, sum_d, term_q, term_d;
    logic         pmul_q, pmul_d;
    logic [W-1:0] s_sum_q, s_sum_d, s_term_q, s_term_d;
    logic         s_pmul_q, s_pmul_d;
    logic [W-1:0] value_q, value_d;
    logic         ok_q, ok_d, err_q, err_d;

    logic         is_digit;
    logic [W-1:0] digit, mul_a, mul_b, mul_y, step_sum;

    assign is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    assign digit    = W'(bus.in[3:0]);

    // One shared multiplier: digit step uses term*d, ')' uses s_term*inner.
    assign mul_a = (st_q == ST_OPND) ? term_q : s_term_q;
    assign mul_b = (st_q == ST_OPND) ? digit  : step_sum;

`ifdef EXPR_EVAL_OVF_EN
    logic         ovf_q, ovf_d, add_c, out_c;
    logic [2*W-1:0] mul_full;
    logic [W-1:0] out_sum;

    assign mul_full        = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    assign mul_y           = mul_full[W-1:0];
    assign {add_c, step_sum} = {1'b0, sum_q} + {1'b0, term_q};
`else
    assign mul_y    = mul_a * mul_b;
    assign step_sum = sum_q + term_q;
`endif

    always_comb begin
        st_d     = st_q;
        depth_d  = depth_q;
        sum_d    = sum_q;
        term_d   = term_q;
        pmul_d   = pmul_q;
        s_sum_d  = s_sum_q;
        s_term_d = s_term_q;
        s_pmul_d = s_pmul_q;
        value_d  = value_q;
`ifdef EXPR_EVAL_OVF_EN
        ovf_d    = ovf_q;
        out_c    = 1'b0;
        out_sum  = '0;
`endif
        if (bus.in_vld && st_q != ST_ERR) begin
            st_d = ST_ERR;
            if (is_digit && st_q == ST_OPND) begin
                term_d = pmul_q ? mul_y : digit;
                st_d   = ST_OPR;
`ifdef EXPR_EVAL_OVF_EN
                if (pmul_q && |mul_full[2*W-1:W]) ovf_d = 1'b1;
`endif
            end else if (bus.in == 8'h2B && st_q == ST_OPR) begin
                sum_d  = step_sum;
                pmul_d = 1'b0;
                st_d   = ST_OPND;
`ifdef EXPR_EVAL_OVF_EN
                if (add_c) ovf_d = 1'b1;
`endif
            end else if (bus.in == 8'h2A && st_q == ST_OPR) begin
                pmul_d = 1'b1;
                st_d   = ST_OPND;
            end else if (bus.in == 8'h28 && st_q == ST_OPND && !depth_q) begin
                s_sum_d  = sum_q;
                s_term_d = term_q;
                s_pmul_d = pmul_q;
                sum_d    = '0;
                term_d   = '0;
                pmul_d   = 1'b0;
                depth_d  = 1'b1;
                st_d     = ST_OPND;
            end else if (bus.in == 8'h29 && st_q == ST_OPR && depth_q) begin
                // Fold the inner sum back into the term that was pending at '('.
                sum_d   = s_sum_q;
                term_d  = s_pmul_q ? mul_y : step_sum;
                pmul_d  = 1'b0;
                depth_d = 1'b0;
                st_d    = ST_OPR;
`ifdef EXPR_EVAL_OVF_EN
                if (add_c || (s_pmul_q && |mul_full[2*W-1:W])) ovf_d = 1'b1;
`endif
            end
            if (st_d != ST_ERR) begin
`ifdef EXPR_EVAL_OVF_EN
                {out_c, out_sum} = {1'b0, sum_d} + {1'b0, term_d};
                value_d = out_sum;
                if (out_c) ovf_d = 1'b1;
`else
                value_d = sum_d + term_d;
`endif
            end
        end
        ok_d  = (st_d == ST_OPR) && !depth_d;
        err_d = (st_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st_q     <= ST_OPND;
            depth_q  <= 1'b0;
            sum_q    <= '0;
            term_q   <= '0;
            pmul_q   <= 1'b0;
            s_sum_q  <= '0;
            s_term_q <= '0;
            s_pmul_q <= 1'b0;
            value_q  <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef EXPR_EVAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            st_q     <= st_d;
            depth_q  <= depth_d;
            sum_q    <= sum_d;
            term_q   <= term_d;
            pmul_q   <= pmul_d;
            s_sum_q  <= s_sum_d;
            s_term_q <= s_term_d;
            s_pmul_q <= s_pmul_d;
            value_q  <= value_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
`ifdef EXPR_EVAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.value = value_q;
    assign bus.ok    = ok_q;
    assign bus.err   = err_q;
`ifdef EXPR_EVAL_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule
